// File: rtl/psum_collector.sv
// psum_collector
//   Drain-side consumer at the bottom of a fusion-unit column. Reduces
//   cfg_len packed partial-sum beats into one per-lane accumulator vector,
//   buffers finished vectors in a small FIFO and offers them downstream.
//
// Ports
//   clk, rst               clock; synchronous active-high reset
//   cfg_start              start a reduction (only looked at in IDLE)
//   cfg_quad               1: NUM_LANES x LANE_W lanes, 0: single ACC_W lane
//   cfg_signed             1: sign-extend quad lanes, 0: zero-extend
//   cfg_len                beats per reduction, 1..256 (0 ignored)
//   psum_valid/ready/data  incoming packed partial sums
//   res_valid/ready/data   FIFO head, {acc[NUM_LANES-1], ..., acc[0]}
//   busy                   reduction in progress (state != IDLE)
module psum_collector #(
    parameter int LANE_W    = 13,
    parameter int NUM_LANES = 4,
    parameter int ACC_W     = 32,
    parameter int DEPTH     = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cfg_start,
    input  logic                         cfg_quad,
    input  logic                         cfg_signed,
    input  logic [8:0]                   cfg_len,
    input  logic                         psum_valid,
    output logic                         psum_ready,
    input  logic [LANE_W*NUM_LANES-1:0]  psum_data,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic [ACC_W*NUM_LANES-1:0]   res_data,
    output logic                         busy
);

    localparam int RES_W = ACC_W * NUM_LANES;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, ACCUM, PUSH} state_t;

    state_t             state_q, state_d;
    logic               quad_q, quad_d;
    logic               sgn_q, sgn_d;
    logic [8:0]         len_q, len_d;
    logic [8:0]         cnt_q, cnt_d;
    logic [ACC_W-1:0]   acc_q [NUM_LANES];
    logic [ACC_W-1:0]   acc_d [NUM_LANES];
    logic [RES_W-1:0]   mem_q [DEPTH];
    logic [RES_W-1:0]   mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]   occ_q, occ_d;
    logic [RES_W-1:0]   acc_vec;
    logic               push;
    logic               pop;

    // Widen one quad lane to accumulator width.
    function automatic logic [ACC_W-1:0] ext_lane(input logic [LANE_W-1:0] lane,
                                                  input logic sgn);
        logic fill;
        fill = sgn & lane[LANE_W-1];
        return {{(ACC_W-LANE_W){fill}}, lane};
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Control FSM and accumulators
    always_comb begin
        state_d    = state_q;
        quad_d     = quad_q;
        sgn_d      = sgn_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        push       = 1'b0;
        psum_ready = 1'b0;
        for (int k = 0; k < NUM_LANES; k++) begin
            acc_vec[ACC_W*k +: ACC_W] = acc_q[k];
        end

        case (state_q)
            IDLE: begin
                if (cfg_start && (cfg_len != 9'd0)) begin
                    quad_d  = cfg_quad;
                    sgn_d   = cfg_signed;
                    len_d   = cfg_len;
                    cnt_d   = 9'd0;
                    for (int k = 0; k < NUM_LANES; k++) acc_d[k] = '0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                psum_ready = 1'b1;
                if (psum_valid) begin
                    if (quad_q) begin
                        for (int k = 0; k < NUM_LANES; k++) begin
                            acc_d[k] = acc_q[k] + ext_lane(psum_data[LANE_W*k +: LANE_W], sgn_q);
                        end
                    end else begin
                        acc_d[0] = acc_q[0] + psum_data[ACC_W-1:0];
                    end
                    cnt_d = cnt_q + 9'd1;
                    if (cnt_q + 9'd1 == len_q) state_d = PUSH;
                end
            end
            PUSH: begin
                // Occupancy at cycle start decides; a concurrent pop does not help.
                if (occ_q < OCC_W'(DEPTH)) begin
                    push    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Result FIFO
    always_comb begin
        pop      = (occ_q != '0) && res_ready;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (push) begin
            mem_d[wr_ptr_q] = acc_vec;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
        if (push && !pop)      occ_d = occ_q + 1'b1;
        else if (!push && pop) occ_d = occ_q - 1'b1;
    end

    assign res_valid = (occ_q != '0);
    // Gate the head so stale storage never shows after reset.
    assign res_data  = res_valid ? mem_q[rd_ptr_q] : '0;
    assign busy      = (state_q != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            quad_q   <= 1'b0;
            sgn_q    <= 1'b0;
            len_q    <= 9'd0;
            cnt_q    <= 9'd0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            for (int k = 0; k < NUM_LANES; k++) acc_q[k] <= '0;
        end else begin
            state_q  <= state_d;
            quad_q   <= quad_d;
            sgn_q    <= sgn_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            acc_q    <= acc_d;
        end
    end

    // FIFO storage carries no reset; validity comes from occ_q.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_psum_collector.sv
module tb_psum_collector;

    localparam int PW = 52;
    localparam int RW = 128;

    logic          clk;
    logic          rst;
    logic          cfg_start;
    logic          cfg_quad;
    logic          cfg_signed;
    logic [8:0]    cfg_len;
    logic          psum_valid;
    logic          psum_ready;
    logic [PW-1:0] psum_data;
    logic          res_valid;
    logic          res_ready;
    logic [RW-1:0] res_data;
    logic          busy;

    psum_collector #(.LANE_W(13), .NUM_LANES(4), .ACC_W(32), .DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .cfg_start(cfg_start), .cfg_quad(cfg_quad), .cfg_signed(cfg_signed), .cfg_len(cfg_len),
        .psum_valid(psum_valid), .psum_ready(psum_ready), .psum_data(psum_data),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [RW-1:0] exp_q [$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting", name);
    endtask

    function automatic logic [RW-1:0] lanes4(input logic [31:0] a3, a2, a1, a0);
        return {a3, a2, a1, a0};
    endfunction

    // Reference reduction.
    function automatic logic [RW-1:0] model(input bit q, input bit s, input logic [PW-1:0] d [$]);
        logic [31:0]        acc [4];
        logic [12:0]        ln;
        logic signed [12:0] sl;
        int                 v;
        for (int k = 0; k < 4; k++) acc[k] = 32'd0;
        foreach (d[i]) begin
            if (q) begin
                for (int k = 0; k < 4; k++) begin
                    ln = d[i][13*k +: 13];
                    sl = ln;
                    if (s) v = sl; else v = int'(ln);
                    acc[k] = acc[k] + v;
                end
            end else begin
                acc[0] = acc[0] + d[i][31:0];
            end
        end
        return {acc[3], acc[2], acc[1], acc[0]};
    endfunction

    // Scoreboard monitor: compares on every accepted result.
    always @(negedge clk) begin
        if (!rst && res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL res_unexpected: got %h expected none", res_data);
            end else begin
                chk("res_data", res_data, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 300) begin tick(); n++; end
        if (busy) fail_timeout("wait_idle");
    endtask

    task automatic start(input logic q, input logic s, input logic [8:0] len);
        wait_idle();
        cfg_quad   = q;
        cfg_signed = s;
        cfg_len    = len;
        cfg_start  = 1'b1;
        tick();
        cfg_start  = 1'b0;
    endtask

    task automatic beat(input logic [PW-1:0] d);
        int n = 0;
        psum_valid = 1'b1;
        psum_data  = d;
        while (!psum_ready && n < 300) begin tick(); n++; end
        if (psum_ready) tick();
        else fail_timeout("beat_accept");
        psum_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin tick(); n++; end
        if (exp_q.size() != 0) fail_timeout("drain");
    endtask

    initial begin
        logic [PW-1:0] dq [$];
        logic [63:0]   rnd;
        logic [PW-1:0] d;
        bit            q, s;

        rst = 1'b1; cfg_start = 1'b0; cfg_quad = 1'b0; cfg_signed = 1'b0; cfg_len = 9'd0;
        psum_valid = 1'b0; psum_data = '0; res_ready = 1'b0;
        repeat (3) tick();
        chk("rst_psum_ready", psum_ready, 0);
        chk("rst_res_valid",  res_valid,  0);
        chk("rst_res_data",   res_data,   0);
        chk("rst_busy",       busy,       0);
        rst = 1'b0;
        tick();

        // 1: quad unsigned len=1 plus write latency
        exp_q.push_back(lanes4(18, 12, 6, 0));
        start(1, 0, 9'd1);
        beat({13'd18, 13'd12, 13'd6, 13'd0});
        chk("lat_edge_n",  res_valid, 0);
        tick();
        chk("lat_edge_n1", res_valid, 1);
        res_ready = 1'b1;
        drain();

        // 2: lane0 all-ones, signed then unsigned
        exp_q.push_back(lanes4(0, 0, 0, 32'hFFFF_FFFE));
        start(1, 1, 9'd2);
        beat(52'h1FFF); beat(52'h1FFF);
        exp_q.push_back(lanes4(0, 0, 0, 32'h0000_3FFE));
        start(1, 0, 9'd2);
        beat(52'h1FFF); beat(52'h1FFF);
        drain();

        // 3: single mode, upper garbage ignored
        exp_q.push_back(lanes4(0, 0, 0, 32'd195075));
        start(0, 1, 9'd3);
        repeat (3) beat({20'hABCDE, 32'd65025});
        drain();

        // 4: full FIFO back-pressure
        res_ready = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            exp_q.push_back(lanes4(0, 0, 0, i));
            start(1, 0, 9'd1);
            beat(PW'(i));
        end
        repeat (3) tick();
        chk("full_busy",       busy,       1);
        chk("full_psum_ready", psum_ready, 0);
        chk("full_res_valid",  res_valid,  1);
        res_ready = 1'b1;
        drain();
        wait_idle();

        // 5: reset mid-reduction with a result parked in the FIFO
        res_ready = 1'b0;
        start(1, 0, 9'd1);
        beat(52'd99);
        start(1, 0, 9'd4);
        beat(52'd1); beat(52'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_busy",       busy,       0);
        chk("mid_rst_res_valid",  res_valid,  0);
        chk("mid_rst_psum_ready", psum_ready, 0);
        chk("mid_rst_res_data",   res_data,   0);
        res_ready = 1'b1;
        exp_q.push_back(lanes4(0, 0, 0, 7));
        start(1, 0, 9'd1);
        beat(52'd7);
        drain();

        // 6: len=0 ignored, then gapped beats with spurious starts
        cfg_start = 1'b1; cfg_len = 9'd0;
        repeat (3) tick();
        cfg_start = 1'b0;
        chk("len0_busy", busy, 0);
        for (int r = 0; r < 4; r++) begin
            q = (r != 1);
            s = (r == 0) || (r == 3);
            dq.delete();
            for (int b = 0; b < 3 + r; b++) begin
                rnd = {$urandom, $urandom};
                d = rnd[PW-1:0];
                dq.push_back(d);
            end
            exp_q.push_back(model(q, s, dq));
            start(q, s, 9'(3 + r));
            foreach (dq[b]) begin
                repeat ($urandom_range(0, 3)) begin
                    cfg_start  = 1'b1;
                    cfg_len    = 9'($urandom_range(1, 5));
                    cfg_quad   = ~cfg_quad;
                    cfg_signed = 1'($urandom);
                    tick();
                end
                cfg_start = 1'b0;
                beat(dq[b]);
            end
            wait_idle();
        end
        drain();
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
